mips_cpu_cache_arbiter: RTL and testbench
=========================================

# mips_cpu_cache_arbiter

Memory-side controller that shares the single Avalon-style memory port between the instruction cache and the data cache. It accepts cache miss requests, grants one at a time, and sequences the bus transfer under `mem_waitrequest`. It returns the fetched word to the requesting cache as a one-cycle `data_valid` pulse that the cache uses to fill its line and release its stall.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of all address ports.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_req` in 1: instruction-cache miss request (its `stall`); held until `i_data_valid`.
- `i_addr` in 32: instruction fetch byte address.
- `i_data` out 32: returned word, driven to the cache's `data_in`.
- `i_data_valid` out 1: one-cycle fill strobe.
- `d_read` in 1: data-cache read-miss request.
- `d_write` in 1: data-cache write-through request.
- `d_addr` in 32: data byte address.
- `d_writedata` in 32: write data.
- `d_byteenable` in 4: write byte lanes.
- `d_data` out 32: returned read word (0 on write acknowledge).
- `d_data_valid` out 1: one-cycle read-fill or write-acknowledge strobe.
- `mem_address` out 32, `mem_read` out 1, `mem_write` out 1, `mem_writedata` out 32, `mem_byteenable` out 4: bus request.
- `mem_waitrequest` in 1, `mem_readdata` in 32: bus response.

## Operation
- FSM states: IDLE, I_RD, D_RD, D_WR, I_RESP, D_RESP.
- IDLE: sample requests and grant at most one.
  - `d_write` goes to D_WR.
  - Else `d_read` goes to D_RD.
  - Else `i_req` goes to I_RD.
  - Simultaneous data and instruction requests are resolved per Configuration.
- `d_write` and `d_read` both high: write wins, and the read is served in the next IDLE.
- I_RD/D_RD: `mem_read`=1, `mem_byteenable`=4'hF, `mem_address` = requester addr with [1:0] forced to 0.
  - Leave on the first edge with `mem_waitrequest`=0, going to I_RESP/D_RESP.
- D_WR: `mem_write`=1, with `mem_address`, `mem_writedata` and `mem_byteenable` taken from the data port. Leave on `mem_waitrequest`=0, going to D_RESP.
- All `mem_*` outputs are registered and held stable for the whole transfer, whatever the requester inputs do.
- Address and write data are latched at grant.
- I_RESP/D_RESP:
  - The strobe is high for exactly one cycle.
  - On reads, `i_data`/`d_data` = `mem_readdata` (combinational pass-through).
  - Then return to IDLE.
- If the requester's request is low in the RESP cycle, the strobe is suppressed. The bus transfer is never aborted.
- Outside RESP, `i_data`/`d_data` = 0.

## Timing
- Reset (async assert): state=IDLE, and every output is 0.
- Round-robin pointer resets to "instruction last granted".
- Reset release is synchronous to the next edge.
- Miss latency with zero wait states:
  - Request seen in IDLE at cycle 0.
  - `mem_read` high in cycle 1.
  - Strobe in cycle 2.
  - Cache hits in cycle 3.
- Each `mem_waitrequest` high cycle adds one cycle.
- One mandatory IDLE cycle between back-to-back transfers.
- `mem_read` and `mem_write` are never high together.
- Requests arriving outside IDLE wait and are not lost, since requesters hold them.

## Configuration
- `CACHE_ARB_RR_EN` defined: on simultaneous data/instruction requests in IDLE, grant the port not granted last.
  - The 1-bit last-grant pointer updates on every grant.
  - After reset, data wins first.
- Not defined: fixed priority, data always beats instruction, and there is no pointer register.

## Test plan
- Instruction miss, zero waits:
  - Stimulus: `i_req`=1, `i_addr`=0xBFC00000, `mem_readdata`=0x24020005.
  - Response: cycle 1 `mem_read`=1 with `mem_address`=0xBFC00000 and byteenable F.
  - Response: cycle 2 `i_data_valid`=1 with `i_data`=0x24020005. Next cycle valid=0.
- Wait states:
  - Stimulus: `mem_waitrequest` high 3 cycles on a D_RD at 0x00001008.
  - Response: `mem_read` and address held 4 cycles, then exactly one `d_data_valid` pulse.
- Contention:
  - Stimulus: `i_req` and `d_read` both held high.
  - Response: data served first, then instruction.
  - With `CACHE_ARB_RR_EN`, a second simultaneous pair goes instruction first. Without it, data first again.
- Write:
  - Stimulus: `d_write`, addr 0x10000004, data 0xDEADBEEF, byteenable 4'b0011.
  - Response: bus carries exactly these values, `mem_read` stays 0, and `d_data_valid` pulses once with `d_data`=0.
- Alignment and drop:
  - Stimulus: `i_addr`=0x00000406.
  - Response: `mem_address`=0x00000404.
  - Stimulus: deassert `i_req` mid-transfer.
  - Response: transfer completes and no `i_data_valid` pulse is issued.
- Reset mid-transfer:
  - Stimulus: `rst` low during D_RD with waitrequest high.
  - Response: `mem_read` drops without waiting for a clock edge, no strobe, FSM in IDLE after release.

Source files
------------

// File: rtl/mips_cpu_cache_arbiter.sv
// Shares one Avalon-style memory port between the instruction and data caches.
// Define CACHE_ARB_RR_EN for round-robin arbitration on simultaneous I/D requests; otherwise data has fixed priority.
module mips_cpu_cache_arbiter #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [31:0]           i_data,
   output logic                  i_data_valid,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [31:0]           d_writedata,
   input  logic [3:0]            d_byteenable,
   output logic [31:0]           d_data,
   output logic                  d_data_valid,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [31:0]           mem_writedata,
   output logic [3:0]            mem_byteenable,
   input  logic                  mem_waitrequest,
   input  logic [31:0]           mem_readdata
);

   typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, I_RESP, D_RESP} state_t;

   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~(ADDR_WIDTH'(3));

   state_t state, next_state;
   logic   grant_data;
   logic   grant_instr;
   logic   is_write;

`ifdef CACHE_ARB_RR_EN
   logic last_instr;

   // Data wins a tie only when the instruction side was granted last.
   assign grant_data = (state == IDLE) && (d_read || d_write) && (!i_req || last_instr);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_instr <= 1'b1;
      else if (grant_data)
         last_instr <= 1'b0;
      else if (grant_instr)
         last_instr <= 1'b1;
   end
`else
   assign grant_data = (state == IDLE) && (d_read || d_write);
`endif

   assign grant_instr = (state == IDLE) && i_req && !grant_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state   = state;
      i_data       = '0;
      i_data_valid = 1'b0;
      d_data       = '0;
      d_data_valid = 1'b0;
      case (state)
         IDLE: begin
            if (grant_data)
               next_state = d_write ? D_WR : D_RD;
            else if (grant_instr)
               next_state = I_RD;
         end
         I_RD: begin
            if (!mem_waitrequest)
               next_state = I_RESP;
         end
         D_RD, D_WR: begin
            if (!mem_waitrequest)
               next_state = D_RESP;
         end
         I_RESP: begin
            next_state   = IDLE;
            i_data       = mem_readdata;
            i_data_valid = i_req;
         end
         D_RESP: begin
            next_state   = IDLE;
            d_data       = is_write ? 32'h0 : mem_readdata;
            d_data_valid = is_write ? d_write : d_read;
         end
         default: next_state = IDLE;
      endcase
   end

   // Bus request is captured at grant and held until the transfer completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_address    <= '0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
         mem_byteenable <= '0;
         is_write       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_data && d_write) begin
                  mem_address    <= d_addr;
                  mem_write      <= 1'b1;
                  mem_writedata  <= d_writedata;
                  mem_byteenable <= d_byteenable;
                  is_write       <= 1'b1;
               end else if (grant_data) begin
                  mem_address    <= d_addr & WORD_MASK;
                  mem_read       <= 1'b1;
                  mem_writedata  <= '0;
                  mem_byteenable <= 4'hF;
                  is_write       <= 1'b0;
               end else if (grant_instr) begin
                  mem_address    <= i_addr & WORD_MASK;
                  mem_read       <= 1'b1;
                  mem_writedata  <= '0;
                  mem_byteenable <= 4'hF;
                  is_write       <= 1'b0;
               end
            end
            I_RD, D_RD, D_WR: begin
               if (!mem_waitrequest) begin
                  mem_address    <= '0;
                  mem_read       <= 1'b0;
                  mem_write      <= 1'b0;
                  mem_writedata  <= '0;
                  mem_byteenable <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_cache_arbiter.sv
// Directed self-checking bench for mips_cpu_cache_arbiter.
// Grant order under contention depends on whether CACHE_ARB_RR_EN is defined.
module tb_mips_cpu_cache_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_data;
   logic        i_data_valid;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_writedata;
   logic [3:0]  d_byteenable;
   logic [31:0] d_data;
   logic        d_data_valid;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_byteenable;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;

   int testsRun;
   int testsFailed;

   mips_cpu_cache_arbiter #(.ADDR_WIDTH(32)) dut (
      .clk(clk),
      .rst(rst),
      .i_req(i_req),
      .i_addr(i_addr),
      .i_data(i_data),
      .i_data_valid(i_data_valid),
      .d_read(d_read),
      .d_write(d_write),
      .d_addr(d_addr),
      .d_writedata(d_writedata),
      .d_byteenable(d_byteenable),
      .d_data(d_data),
      .d_data_valid(d_data_valid),
      .mem_address(mem_address),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_writedata(mem_writedata),
      .mem_byteenable(mem_byteenable),
      .mem_waitrequest(mem_waitrequest),
      .mem_readdata(mem_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic dread,
                                input logic dwrite, input logic [31:0] daddr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic waitreq, input logic [31:0] rdata);
      i_req           = ireq;
      i_addr          = iaddr;
      d_read          = dread;
      d_write         = dwrite;
      d_addr          = daddr;
      d_writedata     = wdata;
      d_byteenable    = be;
      mem_waitrequest = waitreq;
      mem_readdata    = rdata;
   endtask

   task automatic nextCycle();
      @(negedge clk);
      #1;
   endtask

   task automatic clearInputs();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
   endtask

   // Waits for the next bus transfer, checks its address, then runs it to completion.
   task automatic awaitTransfer(input string tag, input logic [31:0] expAddr);
      int n = 0;
      while (!(mem_read || mem_write) && n < 16) begin
         nextCycle();
         n++;
      end
      checkOutput({tag, " started"}, 32'(n < 16), 32'h1);
      checkOutput({tag, " address"}, mem_address, expAddr);
      while ((mem_read || mem_write) && n < 32) begin
         nextCycle();
         n++;
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] secondGrant;
      testsRun    = 0;
      testsFailed = 0;
      rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h5555AAAA);
      #1;
      checkOutput("reset mem_read", 32'(mem_read), 32'h0);
      checkOutput("reset mem_write", 32'(mem_write), 32'h0);
      checkOutput("reset mem_address", mem_address, 32'h0);
      checkOutput("reset mem_byteenable", 32'(mem_byteenable), 32'h0);
      checkOutput("reset i_data_valid", 32'(i_data_valid), 32'h0);
      checkOutput("reset d_data_valid", 32'(d_data_valid), 32'h0);
      checkOutput("reset i_data", i_data, 32'h0);
      checkOutput("reset d_data", d_data, 32'h0);
      nextCycle();
      rst = 1'b1;
      nextCycle();

      // Instruction miss with zero wait states.
      applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h24020005);
      checkOutput("imiss c0 mem_read", 32'(mem_read), 32'h0);
      nextCycle();
      checkOutput("imiss c1 mem_read", 32'(mem_read), 32'h1);
      checkOutput("imiss c1 mem_address", mem_address, 32'hBFC00000);
      checkOutput("imiss c1 byteenable", 32'(mem_byteenable), 32'hF);
      checkOutput("imiss c1 mem_write", 32'(mem_write), 32'h0);
      checkOutput("imiss c1 valid", 32'(i_data_valid), 32'h0);
      nextCycle();
      checkOutput("imiss c2 valid", 32'(i_data_valid), 32'h1);
      checkOutput("imiss c2 i_data", i_data, 32'h24020005);
      checkOutput("imiss c2 mem_read", 32'(mem_read), 32'h0);
      nextCycle();
      checkOutput("imiss c3 valid", 32'(i_data_valid), 32'h0);
      checkOutput("imiss c3 i_data", i_data, 32'h0);
      clearInputs();

      // Data read with three wait states; requester address changes mid-transfer.
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h00001008, 32'h0, 4'h0, 1'b1, 32'h12345678);
      nextCycle();
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("wait %0d mem_read", k), 32'(mem_read), 32'h1);
         checkOutput($sformatf("wait %0d mem_address", k), mem_address, 32'h00001008);
         checkOutput($sformatf("wait %0d d_valid", k), 32'(d_data_valid), 32'h0);
         if (k == 1) d_addr = 32'hFFFF0000;
         if (k == 3) mem_waitrequest = 1'b0;
         nextCycle();
      end
      checkOutput("wait resp d_valid", 32'(d_data_valid), 32'h1);
      checkOutput("wait resp d_data", d_data, 32'h12345678);
      checkOutput("wait resp mem_read", 32'(mem_read), 32'h0);
      nextCycle();
      checkOutput("wait after d_valid", 32'(d_data_valid), 32'h0);
      clearInputs();

      // Contention from a fresh reset so the round-robin pointer is at its initial value.
      rst = 1'b0;
      nextCycle();
      rst = 1'b1;
      nextCycle();
      applyStimulus(1'b1, 32'h00002000, 1'b1, 1'b0, 32'h00003000, 32'h0, 4'h0, 1'b0, 32'h0);
`ifdef CACHE_ARB_RR_EN
      secondGrant = 32'h00002000;
`else
      secondGrant = 32'h00003000;
`endif
      awaitTransfer("contend grant1", 32'h00003000);
      awaitTransfer("contend grant2", secondGrant);
      awaitTransfer("contend grant3", 32'h00003000);
      clearInputs();
      nextCycle();
      nextCycle();

      // Write with a pending read: write goes first, read follows.
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h10000004, 32'hDEADBEEF, 4'b0011, 1'b0, 32'hCAFEF00D);
      nextCycle();
      checkOutput("write mem_write", 32'(mem_write), 32'h1);
      checkOutput("write mem_read", 32'(mem_read), 32'h0);
      checkOutput("write mem_address", mem_address, 32'h10000004);
      checkOutput("write mem_writedata", mem_writedata, 32'hDEADBEEF);
      checkOutput("write mem_byteenable", 32'(mem_byteenable), 32'h3);
      nextCycle();
      checkOutput("write ack d_valid", 32'(d_data_valid), 32'h1);
      checkOutput("write ack d_data", d_data, 32'h0);
      checkOutput("write ack mem_write", 32'(mem_write), 32'h0);
      nextCycle();
      checkOutput("write idle d_valid", 32'(d_data_valid), 32'h0);
      d_write = 1'b0;
      nextCycle();
      checkOutput("read after write mem_read", 32'(mem_read), 32'h1);
      checkOutput("read after write mem_write", 32'(mem_write), 32'h0);
      checkOutput("read after write byteenable", 32'(mem_byteenable), 32'hF);
      nextCycle();
      checkOutput("read after write d_valid", 32'(d_data_valid), 32'h1);
      checkOutput("read after write d_data", d_data, 32'hCAFEF00D);
      clearInputs();
      nextCycle();

      // Unaligned fetch, then the request is dropped mid-transfer.
      applyStimulus(1'b1, 32'h00000406, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h11112222);
      nextCycle();
      checkOutput("align mem_address", mem_address, 32'h00000404);
      checkOutput("align mem_read", 32'(mem_read), 32'h1);
      i_req = 1'b0;
      nextCycle();
      checkOutput("drop mem_read held", 32'(mem_read), 32'h1);
      mem_waitrequest = 1'b0;
      nextCycle();
      checkOutput("drop no i_valid", 32'(i_data_valid), 32'h0);
      checkOutput("drop mem_read done", 32'(mem_read), 32'h0);
      nextCycle();
      checkOutput("drop idle mem_read", 32'(mem_read), 32'h0);
      clearInputs();

      // Reset in the middle of a stalled data read.
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h00000020, 32'h0, 4'h0, 1'b1, 32'h00000033);
      nextCycle();
      checkOutput("midrst before mem_read", 32'(mem_read), 32'h1);
      #1 rst = 1'b0;
      #1;
      checkOutput("midrst async mem_read", 32'(mem_read), 32'h0);
      checkOutput("midrst async mem_address", mem_address, 32'h0);
      checkOutput("midrst d_valid", 32'(d_data_valid), 32'h0);
      nextCycle();
      rst = 1'b1;
      mem_waitrequest = 1'b0;
      nextCycle();
      checkOutput("midrst regrant mem_read", 32'(mem_read), 32'h1);
      checkOutput("midrst regrant d_valid", 32'(d_data_valid), 32'h0);
      nextCycle();
      checkOutput("midrst resp d_valid", 32'(d_data_valid), 32'h1);
      checkOutput("midrst resp d_data", d_data, 32'h00000033);
      clearInputs();
      nextCycle();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
